// File: rtl/pipe_pkg.sv
// Shared pipeline types and defaults for the EX/MEM boundary.
package pipe_pkg;

   localparam int unsigned DATA_WIDTH_DEF = 32;
   localparam int unsigned ADDR_WIDTH_DEF = 5;

   typedef struct packed {
      logic [2:0] RegWrite;
      logic [1:0] ResultSrc;
      logic [1:0] MemWrite;
      logic [2:0] funct3;
   } exmem_ctrl_t;

   typedef struct packed {
      logic [DATA_WIDTH_DEF-1:0] ALUResult;
      logic [DATA_WIDTH_DEF-1:0] WriteData;
      logic [ADDR_WIDTH_DEF-1:0] Rd;
      logic [DATA_WIDTH_DEF-1:0] PCPlus4;
   } exmem_data_t;

endpackage

// File: rtl/skid_buf.sv
// Two-slot valid/ready skid buffer with synchronous flush.
// ready_in depends only on registered state (skid slot occupancy),
// so there is no combinational path from ready_out to ready_in.
module skid_buf #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             valid_in,
   output logic             ready_in,
   input  logic [WIDTH-1:0] data_in,
   output logic             valid_out,
   input  logic             ready_out,
   output logic [WIDTH-1:0] data_out
);

   logic             main_valid_q, main_valid_d;
   logic             skid_valid_q, skid_valid_d;
   logic [WIDTH-1:0] main_data_q, main_data_d;
   logic [WIDTH-1:0] skid_data_q, skid_data_d;
   logic             accept;
   logic             consume;

   assign ready_in  = !skid_valid_q;
   assign valid_out = main_valid_q;
   assign data_out  = main_data_q;

   // Slot steering: refill main from skid first, otherwise take new data
   // into main when it frees up, else park it in the skid slot.
   always_comb begin
      main_valid_d = main_valid_q;
      skid_valid_d = skid_valid_q;
      main_data_d  = main_data_q;
      skid_data_d  = skid_data_q;
      accept       = valid_in && !skid_valid_q;
      consume      = main_valid_q && ready_out;
      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (consume && skid_valid_q) begin
         main_data_d  = skid_data_q;
         main_valid_d = 1'b1;
         skid_valid_d = 1'b0;
      end else if (accept && (!main_valid_q || consume)) begin
         main_data_d  = data_in;
         main_valid_d = 1'b1;
      end else if (accept) begin
         skid_data_d  = data_in;
         skid_valid_d = 1'b1;
      end else if (consume) begin
         main_valid_d = 1'b0;
      end
   end

   // State registers; reset empties both slots and zeroes the payload.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         main_data_q  <= '0;
         skid_data_q  <= '0;
      end else begin
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
         main_data_q  <= main_data_d;
         skid_data_q  <= skid_data_d;
      end
   end

endmodule

// File: rtl/reg_exe_mem_skid.sv
// EX/MEM pipeline register with a 2-entry skid buffer.
// Optional macro EXMEM_STALL_CNT_EN adds a saturating stall_cnt output
// counting cycles with valid_m && !ready_m.
module reg_exe_mem_skid
   import pipe_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  valid_e,
   output logic                  ready_e,
   input  logic [2:0]            RegWriteE,
   input  logic [1:0]            ResultSrcE,
   input  logic [1:0]            MemWriteE,
   input  logic [2:0]            funct3E,
   input  logic [DATA_WIDTH-1:0] ALUResultE,
   input  logic [DATA_WIDTH-1:0] WriteDataE,
   input  logic [ADDR_WIDTH-1:0] RdE,
   input  logic [DATA_WIDTH-1:0] PCPlus4E,
   output logic                  valid_m,
   input  logic                  ready_m,
   output logic [2:0]            RegWriteM,
   output logic [1:0]            ResultSrcM,
   output logic [1:0]            MemWriteM,
   output logic [2:0]            funct3M,
   output logic [DATA_WIDTH-1:0] ALUResultM,
   output logic [DATA_WIDTH-1:0] WriteDataM,
   output logic [ADDR_WIDTH-1:0] RdM,
`ifdef EXMEM_STALL_CNT_EN
   output logic [DATA_WIDTH-1:0] PCPlus4M,
   output logic [15:0]           stall_cnt
`else
   output logic [DATA_WIDTH-1:0] PCPlus4M
`endif
);

   localparam int unsigned PW = $bits(exmem_ctrl_t) + 3*DATA_WIDTH + ADDR_WIDTH;

   exmem_ctrl_t   ctrl_e, ctrl_m;
   logic [PW-1:0] payload_e, payload_m;

   // Pack the E-side bundle into one flat payload.
   always_comb begin
      ctrl_e.RegWrite  = RegWriteE;
      ctrl_e.ResultSrc = ResultSrcE;
      ctrl_e.MemWrite  = MemWriteE;
      ctrl_e.funct3    = funct3E;
      payload_e        = {ctrl_e, ALUResultE, WriteDataE, RdE, PCPlus4E};
   end

   skid_buf #(
      .WIDTH(PW)
   ) u_skid (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .valid_in (valid_e),
      .ready_in (ready_e),
      .data_in  (payload_e),
      .valid_out(valid_m),
      .ready_out(ready_m),
      .data_out (payload_m)
   );

   // Unpack the head entry; bubbles never write the register file or memory.
   always_comb begin
      {ctrl_m, ALUResultM, WriteDataM, RdM, PCPlus4M} = payload_m;
      ResultSrcM = ctrl_m.ResultSrc;
      funct3M    = ctrl_m.funct3;
      RegWriteM  = valid_m ? ctrl_m.RegWrite : '0;
      MemWriteM  = valid_m ? ctrl_m.MemWrite : '0;
   end

`ifdef EXMEM_STALL_CNT_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;

   assign stall_cnt = stall_cnt_q;

   // Saturating count of cycles the head entry is blocked downstream.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (valid_m && !ready_m && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   // Counter register; cleared by reset only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end
`endif

endmodule
